octave_select: RTL and testbench

- Upstream control stage for the octave 7-segment display driver.
- Takes two raw, bouncy push-buttons (octave up / octave down) and runs them through a synchronizer, debouncer and edge detector.
- Maintains a saturating octave register in the range 1..7, which feeds the display driver's 3-bit octave input and the note-frequency logic.

---
 rtl/octave_select.sv | 150 +++++++++++++++
 tb/tb_octave_select.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/octave_select.sv
// Octave up/down button front end: 2-flop synchronizer, debouncer and press detector per button,
// driving a saturating octave register. Define AUTOREPEAT_EN to add hold-to-repeat timers.
module octave_select #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int OCT_MIN         = 1,
  parameter int OCT_MAX         = 7,
  parameter int OCT_RESET       = 4,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 20000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up,
  input  logic       btn_down,
  output logic [2:0] octave,
  output logic       octave_changed,
  output logic       at_limit
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic AT_LIMIT_RST = (OCT_RESET == OCT_MIN) || (OCT_RESET == OCT_MAX);

  // Catch parameter sets that cannot fit the 3-bit octave or would never debounce.
  generate
    if (OCT_MIN < 1 || OCT_MAX > 7 || OCT_MIN > OCT_MAX || OCT_RESET < OCT_MIN ||
        OCT_RESET > OCT_MAX || DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1)
    begin : g_bad_params
      $error("octave_select: illegal parameter set");
    end
  endgenerate

  logic [1:0] raw;
  logic [1:0] step;     // bit 0 = up, bit 1 = down

  assign raw = {btn_down, btn_up};

`ifdef AUTOREPEAT_EN
  localparam int RP_W = $clog2((REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD) + 1);
  logic [1:0] level_vec;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_btn
      logic            sync1_reg;
      logic            sync2_reg;
      logic            level_reg;
      logic            level_prev_reg;
      logic [DB_W-1:0] cnt_reg;
      logic            press;

      // The level only flips once DEBOUNCE_CYCLES+1 consecutive samples disagree with it,
      // so any excursion of DEBOUNCE_CYCLES samples or fewer is rejected.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          sync1_reg      <= 1'b0;
          sync2_reg      <= 1'b0;
          level_reg      <= 1'b0;
          level_prev_reg <= 1'b0;
          cnt_reg        <= '0;
        end else begin
          sync1_reg      <= raw[gi];
          sync2_reg      <= sync1_reg;
          level_prev_reg <= level_reg;
          if (sync2_reg != level_reg) begin
            if (cnt_reg == DB_W'(DEBOUNCE_CYCLES)) begin
              level_reg <= ~level_reg;
              cnt_reg   <= '0;
            end else begin
              cnt_reg <= cnt_reg + 1'b1;
            end
          end else begin
            cnt_reg <= '0;
          end
        end
      end

      assign press = level_reg & ~level_prev_reg;

`ifdef AUTOREPEAT_EN
      logic [RP_W-1:0] timer_reg;
      logic            repeating_reg;
      logic            single;
      logic            fire;

      assign level_vec[gi] = level_reg;
      // Timers only run while this button alone is held; holding both freezes them at 0.
      assign single = level_reg & ~level_vec[1-gi];
      assign fire   = single & (repeating_reg ? (timer_reg == RP_W'(REPEAT_PERIOD))
                                              : (timer_reg == RP_W'(REPEAT_DELAY)));

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          timer_reg     <= '0;
          repeating_reg <= 1'b0;
        end else if (single) begin
          if (fire) begin
            timer_reg     <= RP_W'(1);
            repeating_reg <= 1'b1;
          end else begin
            timer_reg <= timer_reg + 1'b1;
          end
        end else begin
          timer_reg     <= '0;
          repeating_reg <= 1'b0;
        end
      end

      assign step[gi] = press | fire;
`else
      assign step[gi] = press;
`endif
    end
  endgenerate

  logic [2:0] octave_reg, octave_next;
  logic       changed_reg, changed_next;
  logic       at_limit_reg, at_limit_next;

  // Simultaneous up and down requests cancel; steps past either limit are dropped.
  always_comb begin
    octave_next  = octave_reg;
    changed_next = 1'b0;
    if (step == 2'b01 && octave_reg < 3'(OCT_MAX)) begin
      octave_next  = octave_reg + 3'd1;
      changed_next = 1'b1;
    end else if (step == 2'b10 && octave_reg > 3'(OCT_MIN)) begin
      octave_next  = octave_reg - 3'd1;
      changed_next = 1'b1;
    end
    at_limit_next = (octave_next == 3'(OCT_MIN)) || (octave_next == 3'(OCT_MAX));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      octave_reg   <= 3'(OCT_RESET);
      changed_reg  <= 1'b0;
      at_limit_reg <= AT_LIMIT_RST;
    end else begin
      octave_reg   <= octave_next;
      changed_reg  <= changed_next;
      at_limit_reg <= at_limit_next;
    end
  end

  assign octave         = octave_reg;
  assign octave_changed = changed_reg;
  assign at_limit       = at_limit_reg;

endmodule

// File: tb/tb_octave_select.sv
// Bench for octave_select: table of press vectors, hand-written latency/reset/repeat sequences
// and random button traffic, all checked every cycle against a history-based reference model.
module tb_octave_select;

  localparam int DB = 4;
  localparam int RD = 20;
  localparam int RP = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_up = 1'b0;
  logic       btn_down = 1'b0;
  logic [2:0] octave;
  logic       octave_changed;
  logic       at_limit;

  always #5 clk = ~clk;

  octave_select #(
    .DEBOUNCE_CYCLES(DB),
    .OCT_MIN(1),
    .OCT_MAX(7),
    .OCT_RESET(4),
    .REPEAT_DELAY(RD),
    .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_up(btn_up),
    .btn_down(btn_down),
    .octave(octave),
    .octave_changed(octave_changed),
    .at_limit(at_limit)
  );

  int checks = 0;
  int errors = 0;
  int ec = 0;
  int pulse_edges[$];

  // Reference model: raw samples indexed by edge number since reset release.
  bit raw_hist[2][64];
  int mk = 0;
  bit lv[2];
  bit lvp[2];
  int age[2];
  int m_oct = 4;
  bit m_chg = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit raw_at(input int b, input int k);
    if (k < 0) return 1'b0;
    return raw_hist[b][k % 64];
  endfunction

  task automatic model_reset();
    mk = 0;
    m_oct = 4;
    m_chg = 0;
    for (int b = 0; b < 2; b++) begin
      lv[b] = 0; lvp[b] = 0; age[b] = 0;
      for (int i = 0; i < 64; i++) raw_hist[b][i] = 0;
    end
  endtask

  task automatic model_edge();
    bit old_lv[2];
    bit ev[2];
    if (rst) begin
      model_reset();
      return;
    end
    raw_hist[0][mk % 64] = btn_up;
    raw_hist[1][mk % 64] = btn_down;
    old_lv[0] = lv[0];
    old_lv[1] = lv[1];
    for (int b = 0; b < 2; b++) begin
      bit all_diff;
      ev[b] = old_lv[b] & ~lvp[b];
      // synced sample at edge k is the raw value from edge k-2; a flip needs DB+1 disagreeing samples
      all_diff = 1;
      for (int j = 0; j <= DB; j++)
        if (raw_at(b, mk - 2 - j) == old_lv[b]) all_diff = 0;
      lvp[b] = old_lv[b];
      lv[b]  = all_diff ? ~old_lv[b] : old_lv[b];
`ifdef AUTOREPEAT_EN
      if (old_lv[b] && !old_lv[1-b]) age[b]++;
      else age[b] = 0;
      if (age[b] > RD && ((age[b] - 1 - RD) % RP) == 0) ev[b] = 1;
`endif
    end
    m_chg = 0;
    if (ev[0] && !ev[1] && m_oct < 7) begin
      m_oct++; m_chg = 1;
    end else if (ev[1] && !ev[0] && m_oct > 1) begin
      m_oct--; m_chg = 1;
    end
    mk++;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    ec++;
    chk("octave", octave, m_oct);
    chk("octave_changed", octave_changed, m_chg);
    chk("at_limit", at_limit, (m_oct == 1 || m_oct == 7) ? 1 : 0);
    if (octave_changed) pulse_edges.push_back(ec);
  endtask

  task automatic do_reset();
    btn_up = 0;
    btn_down = 0;
    rst = 1;
    cycle();
    cycle();
    rst = 0;
    ec = 0;
    pulse_edges.delete();
  endtask

  task automatic press(input bit up, input bit dn, input int hold, input int gap);
    btn_up = up;
    btn_down = dn;
    repeat (hold) cycle();
    btn_up = 0;
    btn_down = 0;
    repeat (gap) cycle();
  endtask

  typedef struct {
    bit up;
    bit dn;
    int hold;
    int gap;
    int exp_oct;
    int exp_pulses;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int first_edge;
    model_reset();

    vecs.push_back('{1, 0, 3, 5, 4, 0});
    vecs.push_back('{1, 0, 3, 5, 4, 0});
    vecs.push_back('{1, 0, 3, 5, 4, 0});
    vecs.push_back('{1, 0, 4, 10, 4, 0});
    vecs.push_back('{1, 0, 10, 10, 5, 1});
    vecs.push_back('{1, 0, 10, 10, 6, 1});
    vecs.push_back('{1, 0, 10, 10, 7, 1});
    vecs.push_back('{1, 0, 10, 10, 7, 0});
    vecs.push_back('{0, 1, 10, 10, 6, 1});
    vecs.push_back('{0, 1, 10, 10, 5, 1});
    vecs.push_back('{0, 1, 10, 10, 4, 1});
    vecs.push_back('{0, 1, 10, 10, 3, 1});
    vecs.push_back('{0, 1, 10, 10, 2, 1});
    vecs.push_back('{0, 1, 10, 10, 1, 1});
    vecs.push_back('{0, 1, 10, 10, 1, 0});
    vecs.push_back('{1, 0, 10, 10, 2, 1});
    vecs.push_back('{1, 1, 10, 10, 2, 0});
    vecs.push_back('{0, 1, 10, 10, 1, 1});

    // Reset state
    do_reset();
    chk("reset_octave", octave, 4);
    chk("reset_changed", octave_changed, 0);
    chk("reset_at_limit", at_limit, 0);

    // Latency: raw up sampled from edge 10, octave must change at edge 17
    repeat (9) cycle();
    btn_up = 1;
    repeat (40) cycle();
    btn_up = 0;
    repeat (10) cycle();
    first_edge = (pulse_edges.size() > 0) ? pulse_edges[0] : -1;
    chk("latency_edge", first_edge, 17);
`ifndef AUTOREPEAT_EN
    chk("hold_pulses", pulse_edges.size(), 1);
    chk("hold_octave", octave, 5);
`endif
    $display("latency first_edge=%0d pulses=%0d octave=%0d", first_edge, pulse_edges.size(), octave);

    // Table of press vectors from a fresh reset
    do_reset();
    for (int i = 0; i < vecs.size(); i++) begin
      pulse_edges.delete();
      press(vecs[i].up, vecs[i].dn, vecs[i].hold, vecs[i].gap);
      chk($sformatf("vec%0d_octave", i), octave, vecs[i].exp_oct);
      chk($sformatf("vec%0d_pulses", i), pulse_edges.size(), vecs[i].exp_pulses);
      $display("vec %0d up=%0d down=%0d hold=%0d octave=%0d pulses=%0d",
               i, vecs[i].up, vecs[i].dn, vecs[i].hold, octave, pulse_edges.size());
    end
    chk("table_at_limit", at_limit, 1);

    // Asynchronous reset assertion mid-cycle, no clock edge in between
    #3;
    rst = 1;
    #1;
    chk("async_octave", octave, 4);
    chk("async_changed", octave_changed, 0);
    chk("async_at_limit", at_limit, 0);
    $display("async reset octave=%0d", octave);
    cycle();
    rst = 0;
    ec = 0;
    pulse_edges.delete();

    // Reset mid-debounce while held: re-debounce after release, exactly one step
    btn_up = 1;
    repeat (3) cycle();
    rst = 1;
    repeat (2) cycle();
    rst = 0;
    pulse_edges.delete();
    repeat (16) cycle();
    btn_up = 0;
    repeat (10) cycle();
    chk("midhold_octave", octave, 5);
    chk("midhold_pulses", pulse_edges.size(), 1);
    $display("reset mid-hold octave=%0d pulses=%0d", octave, pulse_edges.size());

`ifdef AUTOREPEAT_EN
    begin
      int exp_off[6] = '{0, 20, 28, 36, 44, 52};
      do_reset();
      press(0, 1, 10, 10);
      press(0, 1, 10, 10);
      press(0, 1, 10, 10);
      chk("rep_start_octave", octave, 1);
      pulse_edges.delete();
      btn_up = 1;
      repeat (60) cycle();
      btn_up = 0;
      repeat (10) cycle();
      chk("rep_pulses", pulse_edges.size(), 6);
      for (int i = 1; i < 6 && i < pulse_edges.size(); i++)
        chk($sformatf("rep_offset%0d", i), pulse_edges[i] - pulse_edges[0], exp_off[i]);
      chk("rep_octave", octave, 7);
      $display("autorepeat pulses=%0d octave=%0d", pulse_edges.size(), octave);
    end
`endif

    // Random button traffic with occasional resets, checked every cycle by the model
    do_reset();
    for (int i = 0; i < 300; i++) begin
      int len;
      btn_up   = ($urandom_range(0, 2) == 0);
      btn_down = ($urandom_range(0, 2) == 0);
      len = $urandom_range(1, 14);
      if ($urandom_range(0, 40) == 0) begin
        rst = 1;
        cycle();
        rst = 0;
      end
      repeat (len) cycle();
    end
    $display("random traffic done octave=%0d", octave);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
